// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: PCSrc select codes, FSM states and
// the fixed trap vector addresses decoded by the PC datapath.
package pc_sequencer_pkg;

  localparam logic [2:0] PCS_PLUS4  = 3'b000;
  localparam logic [2:0] PCS_BRANCH = 3'b001;
  localparam logic [2:0] PCS_J      = 3'b010;
  localparam logic [2:0] PCS_JR     = 3'b011;
  localparam logic [2:0] PCS_ILLOP  = 3'b100;
  localparam logic [2:0] PCS_XADR   = 3'b101;

  localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
  localparam logic [31:0] XADR_ADDR  = 32'h8000_0008;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_hazard_detect.sv
// Load-use comparator: stall when the load in EX writes a register that the
// ID instruction reads. Register 0 never causes a stall.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       stall
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);
  assign stall    = ex_mem_read && (ex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pc_sequencer.sv
// Pipeline control: picks the PCSrc select, stall and flush controls each
// cycle, and sequences interrupt pending/hold-off so each IRQ vectors once.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int IRQ_HOLDOFF = 2,
  parameter int HCNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IRQ,
  input  logic       kernel,
  input  logic       ID_jump,
  input  logic       ID_jr,
  input  logic       ID_illegal,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rt,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_rt,
  input  logic       EX_branch,
  input  logic       EX_taken,
  output logic [2:0] PCSrc,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       epc_write,
  output logic       irq_ack
);

  seq_state_e        state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              irq_pending_q, irq_pending_d;

  logic load_use_stall;
  logic irq_take;

  hazard_detect u_hazard_detect (
    .ex_mem_read (EX_MemRead),
    .ex_rt       (EX_rt),
    .id_rs       (ID_rs),
    .id_rt       (ID_rt),
    .id_uses_rt  (ID_uses_rt),
    .stall       (load_use_stall)
  );

  // Fixed-priority arbitration; outputs are forced to their idle values
  // while reset is asserted regardless of the decode inputs.
  always_comb begin
    PCSrc       = PCS_PLUS4;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    epc_write   = 1'b0;
    irq_ack     = 1'b0;
    irq_take    = 1'b0;
    if (!reset) begin
      if (EX_branch && EX_taken) begin
        PCSrc       = PCS_BRANCH;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (ID_illegal && !kernel) begin
        PCSrc       = PCS_XADR;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        epc_write   = 1'b1;
      end else if (load_use_stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (irq_pending_q && (state_q == RUN) && !kernel && !ID_jump && !ID_jr) begin
        // The ID instruction is squashed; EPC points at it so eret resumes there.
        PCSrc       = PCS_ILLOP;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        epc_write   = 1'b1;
        irq_ack     = 1'b1;
        irq_take    = 1'b1;
      end else if (ID_jr) begin
        PCSrc       = PCS_JR;
        if_id_flush = 1'b1;
      end else if (ID_jump) begin
        PCSrc       = PCS_J;
        if_id_flush = 1'b1;
      end
    end
  end

  // A take in the same cycle as a new request wins, so one IRQ level never
  // produces two back-to-back vector fetches.
  always_comb begin
    irq_pending_d = irq_pending_q || (IRQ && !kernel);
    if (irq_take) begin
      irq_pending_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      RUN: begin
        if (irq_take) begin
          state_d = HOLD;
          hcnt_d  = HCNT_W'(IRQ_HOLDOFF);
        end
      end
      HOLD: begin
        if (hcnt_q <= HCNT_W'(1)) begin
          state_d = RUN;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q - HCNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      hcnt_q        <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      irq_pending_q <= irq_pending_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one line per checked cycle, expected
// output vectors written by hand from the priority rules.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       IRQ, kernel, ID_jump, ID_jr, ID_illegal, ID_uses_rt;
  logic [4:0] ID_rs, ID_rt, EX_rt;
  logic       EX_MemRead, EX_branch, EX_taken;
  logic [2:0] PCSrc;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush, epc_write, irq_ack;

  int tests_run    = 0;
  int tests_failed = 0;

  // {PCSrc, pc_write, if_id_write, if_id_flush, id_ex_flush, epc_write, irq_ack}
  localparam logic [8:0] V_NORMAL = 9'b000_11_0000;
  localparam logic [8:0] V_BRANCH = 9'b001_11_1100;
  localparam logic [8:0] V_J      = 9'b010_11_1000;
  localparam logic [8:0] V_JR     = 9'b011_11_1000;
  localparam logic [8:0] V_ILLOP  = 9'b100_11_1111;
  localparam logic [8:0] V_XADR   = 9'b101_11_1110;
  localparam logic [8:0] V_STALL  = 9'b000_00_0100;

  pc_sequencer #(.IRQ_HOLDOFF(2), .HCNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .IRQ         (IRQ),
    .kernel      (kernel),
    .ID_jump     (ID_jump),
    .ID_jr       (ID_jr),
    .ID_illegal  (ID_illegal),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .ID_uses_rt  (ID_uses_rt),
    .EX_MemRead  (EX_MemRead),
    .EX_rt       (EX_rt),
    .EX_branch   (EX_branch),
    .EX_taken    (EX_taken),
    .PCSrc       (PCSrc),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .epc_write   (epc_write),
    .irq_ack     (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %-16s got=%b expected=%b", tag, got, exp);
    end else begin
      $display("[TB] ok   %-16s out=%b", tag, got);
    end
  endtask

  function automatic logic [8:0] outs();
    return {PCSrc, pc_write, if_id_write, if_id_flush, id_ex_flush, epc_write, irq_ack};
  endfunction

  // Advance to just after the next rising edge; inputs are then changed and
  // outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ID_jump = 0; ID_jr = 0; ID_illegal = 0; ID_uses_rt = 0;
    ID_rs = 0; ID_rt = 0; EX_rt = 0;
    EX_MemRead = 0; EX_branch = 0; EX_taken = 0;
  endtask

  task automatic settle_check(input string tag, input logic [8:0] exp);
    #1;
    check(tag, outs(), exp);
  endtask

  initial begin
    clear_inputs();
    reset = 1; IRQ = 1; kernel = 0;
    EX_branch = 1; EX_taken = 1;
    #3 check("rst_out", outs(), V_NORMAL);
    tick();
    settle_check("rst_hold", V_NORMAL);

    // Release reset with IRQ high: nothing pending yet this cycle.
    tick();
    EX_branch = 0; EX_taken = 0; reset = 0;
    settle_check("rel_first", V_NORMAL);
    tick();
    settle_check("irq_take_t", V_ILLOP);
    tick();
    settle_check("holdoff_t1", V_NORMAL);
    tick();
    settle_check("holdoff_t2", V_NORMAL);
    tick();
    IRQ = 0;
    settle_check("irq_take_t3", V_ILLOP);

    // One-cycle IRQ pulse during hold-off must survive until RUN.
    tick();
    IRQ = 1;
    settle_check("hold_a", V_NORMAL);
    tick();
    IRQ = 0;
    settle_check("hold_b", V_NORMAL);
    tick();
    EX_branch = 1; EX_taken = 1; ID_jump = 1;
    settle_check("br_over_irq", V_BRANCH);
    tick();
    clear_inputs();
    settle_check("irq_after_br", V_ILLOP);

    // Load-use beats jr; jr proceeds once the load clears.
    tick();
    EX_MemRead = 1; EX_rt = 5; ID_rs = 5; ID_jr = 1;
    settle_check("lu_stall_jr", V_STALL);
    tick();
    EX_MemRead = 0;
    settle_check("jr_after_stall", V_JR);
    tick();
    clear_inputs();
    EX_MemRead = 1; EX_rt = 0; ID_rs = 0;
    settle_check("lu_r0", V_NORMAL);
    tick();
    EX_rt = 7; ID_rt = 7; ID_rs = 3; ID_uses_rt = 0;
    settle_check("lu_rt_unused", V_NORMAL);
    tick();
    ID_uses_rt = 1;
    settle_check("lu_rt", V_STALL);

    tick();
    clear_inputs();
    ID_illegal = 1; kernel = 0;
    settle_check("illegal", V_XADR);
    tick();
    kernel = 1;
    settle_check("illegal_kernel", V_NORMAL);
    tick();
    ID_illegal = 0; ID_jump = 1;
    settle_check("jump", V_J);

    // Pending interrupt deferred by kernel mode, then by a jump in ID.
    tick();
    ID_jump = 0; kernel = 0; IRQ = 1;
    settle_check("irq_set", V_NORMAL);
    tick();
    IRQ = 0; kernel = 1;
    settle_check("irq_kernel_a", V_NORMAL);
    tick();
    settle_check("irq_kernel_b", V_NORMAL);
    tick();
    kernel = 0; ID_jump = 1;
    settle_check("irq_vs_j", V_J);
    tick();
    ID_jump = 0;
    settle_check("irq_deferred", V_ILLOP);

    // Reset in HOLD with a request pending drops the request.
    tick();
    IRQ = 1;
    settle_check("hold_pend", V_NORMAL);
    tick();
    IRQ = 0; reset = 1;
    settle_check("rst_mid_hold", V_NORMAL);
    tick();
    reset = 0;
    settle_check("rst_discard", V_NORMAL);
    tick();
    settle_check("rst_discard2", V_NORMAL);

    tick();
    ID_illegal = 1; EX_MemRead = 1; EX_rt = 5; ID_rs = 5;
    settle_check("ill_over_stall", V_XADR);
    tick();
    EX_branch = 1; EX_taken = 1;
    settle_check("br_over_ill", V_BRANCH);
    tick();
    EX_taken = 0;
    settle_check("br_not_taken", V_XADR);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Pipeline control unit that drives the 3-bit PCSrc select of the PC datapath and the pipeline write/flush controls.
- Arbitrates, in one fixed priority order, between:
  - taken branches resolved in EX
  - illegal-instruction exceptions in ID
  - load-use stalls
  - external interrupts
  - jr and j in ID
- Owns interrupt pending/hold-off sequencing so that exactly one vector fetch happens per interrupt.
- Sits between the ID/EX decode outputs and PC_datapath / pipeline registers.

Parameters:
- IRQ_HOLDOFF, 2, cycles after an interrupt is taken during which a new interrupt cannot be taken (1..15).
- HCNT_W, 4, width of the hold-off counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IRQ  in  1  level interrupt request from timer/peripheral.
- kernel  in  1  PC[31] of the IF-stage PC; 1 = supervisor mode, masks IRQ and illegal-op trapping.
- ID_jump  in  1  j/jal decoded in ID.
- ID_jr  in  1  jr/jalr decoded in ID.
- ID_illegal  in  1  undefined opcode/funct decoded in ID.
- ID_rs  in  5  rs field of the ID instruction.
- ID_rt  in  5  rt field of the ID instruction.
- ID_uses_rt  in  1  ID instruction reads rt as a source.
- EX_MemRead  in  1  load in EX.
- EX_rt  in  5  destination rt of the load in EX.
- EX_branch  in  1  conditional branch in EX.
- EX_taken  in  1  ALUOut[0] of the EX branch compare.
- PCSrc  out  3  000 PC+4, 001 branch, 010 J target, 011 jr, 100 ILLOP (interrupt), 101 XADR (exception).
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register is loaded with a nop.
- id_ex_flush  out  1  ID/EX register is loaded with a bubble.
- epc_write  out  1  capture the ID-stage PC into $26 (EPC) this cycle.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.

Behaviour:

Reset (asynchronous):
- Clears irq_pending and the hold-off counter; the state returns to RUN.
- While reset is high, outputs are: PCSrc=000, pc_write=1, if_id_write=1, all flush/epc/ack outputs = 0.

State and counter:
- States: RUN and HOLD.
- HOLD is entered on an interrupt take, with hcnt loaded to IRQ_HOLDOFF.
- In HOLD, hcnt decrements each cycle; HOLD returns to RUN when hcnt reaches 1.

irq_pending:
- Set on any clock where IRQ=1 and kernel=0.
- Cleared only on an interrupt take or reset.
- A set and a take in the same cycle results in a clear.

Per-cycle priority (combinational from registered state plus inputs); the first matching rule wins:
1. Taken branch (EX_branch & EX_taken): PCSrc=001, if_id_flush=1, id_ex_flush=1.
2. Illegal instruction (ID_illegal & !kernel): PCSrc=101, if_id_flush=1, id_ex_flush=1, epc_write=1.
3. Load-use hazard (EX_MemRead & EX_rt!=0 & (EX_rt==ID_rs | (ID_uses_rt & EX_rt==ID_rt))):
   - pc_write=0, if_id_write=0, id_ex_flush=1, PCSrc=000.
   - Hazard detection takes priority over jr/j in ID, so those re-evaluate the next cycle.
4. Interrupt take (irq_pending & state==RUN & !kernel & !ID_jump & !ID_jr):
   - PCSrc=100, if_id_flush=1, id_ex_flush=1, epc_write=1, irq_ack=1.
   - The ID instruction is discarded and re-executes after eret via jr $26.
5. ID_jr: PCSrc=011, if_id_flush=1.
6. ID_jump: PCSrc=010, if_id_flush=1.
7. Otherwise: PCSrc=000; pc_write and if_id_write = 1; flushes = 0.

Interrupt deferral:
- A pending interrupt blocked by rules 1–3, by a jump in ID, or by HOLD is not lost.
- It is taken on the first cycle the rule-4 conditions hold.

Boundary conditions:
- IRQ deasserted after irq_pending is set: the interrupt is still taken.
- kernel=1 while pending: the take is deferred until kernel=0; pending persists.
- Reset mid-HOLD or while an interrupt is pending: the pending interrupt is discarded.
- Codes 110 and 111 are never driven.
- Outputs other than irq_pending, state and hcnt are purely combinational; no added latency.

Decomposition:
- Shared package holds:
  - PCSrc code constants (PCS_PLUS4, PCS_BRANCH, PCS_J, PCS_JR, PCS_ILLOP, PCS_XADR)
  - the state encoding (RUN, HOLD)
  - ILLOP/XADR addresses (0x8000_0004, 0x8000_0008)
- One sub-module: hazard_detect, the combinational load-use comparator producing the stall signal.
- The remaining logic stays in pc_sequencer.

Test Plan:
- Reset while IRQ=1 and kernel=0 → all outputs at reset values; first cycle after release: irq_pending=0 and PCSrc=000; the following cycle: irq_ack=1 and PCSrc=100.
- EX_branch=1, EX_taken=1, with ID_jump=1 and irq_pending=1 in the same cycle → PCSrc=001, both flushes=1, irq_ack=0; next cycle with no branch → PCSrc=100, irq_ack=1.
- EX_MemRead=1, EX_rt=5, ID_rs=5, ID_jr=1 → pc_write=0, if_id_write=0, id_ex_flush=1; next cycle with EX_MemRead=0 → PCSrc=011, if_id_flush=1.
- EX_MemRead=1, EX_rt=0, ID_rs=0 → no stall; PCSrc=000.
- ID_illegal=1, kernel=0 → PCSrc=101, epc_write=1; same stimulus with kernel=1 → PCSrc=000, epc_write=0.
- IRQ held high with IRQ_HOLDOFF=2 and kernel forced 0 → irq_ack at cycle t, no irq_ack at t+1 or t+2, irq_ack again at t+3.
